// File: rtl/register_file_pkg.sv
// Shared constants and types for the 16-entry architectural register file.
package register_file_pkg;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;

  typedef logic [3:0] reg_idx_t;

  localparam reg_idx_t REG_PC = 4'd15;
endpackage

// File: rtl/register_file_decoder.sv
// 4-to-16 write decoder: one-hot register enable, all-zero when LE is low.
module decoder
  import register_file_pkg::*;
(
  input  logic                LE,
  input  reg_idx_t            RW,
  output logic [NUM_REGS-1:0] regnum
);

  always_comb begin
    regnum = '0;
    if (LE) regnum[RW] = 1'b1;
  end

endmodule

// File: rtl/register_file.sv
// 16 x DATA_W register file, R15 = PC; three bypassed read ports, one WB write port, PC-load port.
module register_file #(
  parameter int                DATA_W   = register_file_pkg::DATA_W,
  parameter logic [DATA_W-1:0] PC_RESET = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        le,
  input  register_file_pkg::reg_idx_t rw,
  input  logic [DATA_W-1:0]           pw,
  input  register_file_pkg::reg_idx_t ra,
  input  register_file_pkg::reg_idx_t rb,
  input  register_file_pkg::reg_idx_t rd,
  output logic [DATA_W-1:0]           pa,
  output logic [DATA_W-1:0]           pb,
  output logic [DATA_W-1:0]           pd,
  input  logic                        pc_le,
  input  logic [DATA_W-1:0]           pc_in,
  output logic [DATA_W-1:0]           pc_out
);
  import register_file_pkg::*;

  logic [NUM_REGS-1:0] we;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];

  decoder u_dec (
    .LE     (le),
    .RW     (rw),
    .regnum (we)
  );

  // A WB write to R15 overrides a simultaneous PC load (branch via write).
  always_comb begin
    regs_d = regs_q;
    for (int k = 0; k < NUM_REGS; k++)
      if (we[k]) regs_d[k] = pw;
    if (pc_le && !we[REG_PC]) regs_d[REG_PC] = pc_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
      regs_q[REG_PC] <= PC_RESET;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Write-through: the value WB is writing this cycle is visible to ID; pc_le never bypasses.
  function automatic logic [DATA_W-1:0] sel_read(input reg_idx_t sel);
    if (le && rw == sel) return pw;
    return regs_q[sel];
  endfunction

  always_comb begin
    pa = sel_read(ra);
    pb = sel_read(rb);
    pd = sel_read(rd);
  end

  assign pc_out = regs_q[REG_PC];

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset, write/read, bypass, PC load, PC conflict, mid-stream reset.
module tb_register_file;
  logic        clk = 1'b0;
  logic        rst_n, le, pc_le;
  logic [3:0]  rw, ra, rb, rd;
  logic [31:0] pw, pc_in, pa, pb, pd, pc_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  register_file #(.DATA_W(32), .PC_RESET(32'h0)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .le     (le),
    .rw     (rw),
    .pw     (pw),
    .ra     (ra),
    .rb     (rb),
    .rd     (rd),
    .pa     (pa),
    .pb     (pb),
    .pd     (pd),
    .pc_le  (pc_le),
    .pc_in  (pc_in),
    .pc_out (pc_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; le = 1'b0; pc_le = 1'b0;
    rw = 4'd0; ra = 4'd0; rb = 4'd0; rd = 4'd0;
    pw = 32'h0; pc_in = 32'h0;
    // Junk on the write ports during reset must be discarded
    #1; le = 1'b1; rw = 4'd3; pw = 32'hFFFF_FFFF; pc_le = 1'b1; pc_in = 32'h55;
    tick();
    rst_n = 1'b1; le = 1'b0; pc_le = 1'b0;

    // T1 reset
    ra = 4'd3; rb = 4'd15; rd = 4'd0; #1;
    check("t1_pa_r3", pa, 32'h0);
    check("t1_pb_r15", pb, 32'h0);
    check("t1_pd_r0", pd, 32'h0);
    check("t1_pc_out", pc_out, 32'h0);

    // T2 write/read
    le = 1'b1; rw = 4'd5; pw = 32'hDEADBEEF;
    tick();
    le = 1'b0; ra = 4'd5; rb = 4'd5; rd = 4'd5; #1;
    check("t2_pa", pa, 32'hDEADBEEF);
    check("t2_pb", pb, 32'hDEADBEEF);
    check("t2_pd", pd, 32'hDEADBEEF);
    ra = 4'd4; rb = 4'd6; rd = 4'd14; #1;
    check("t2_r4", pa, 32'h0);
    check("t2_r6", pb, 32'h0);
    check("t2_r14", pd, 32'h0);
    tick();
    ra = 4'd5; #1;
    check("t2_hold_le0", pa, 32'hDEADBEEF);

    // T3 bypass
    le = 1'b1; rw = 4'd7; pw = 32'h1234; ra = 4'd7; rd = 4'd5; #1;
    check("t3_bypass", pa, 32'h1234);
    check("t3_other_no_bypass", pd, 32'hDEADBEEF);
    le = 1'b0; #1;
    check("t3_old_r7", pa, 32'h0);
    le = 1'b1;
    tick();
    le = 1'b0; #1;
    check("t3_r7_written", pa, 32'h1234);

    // T4 PC load, read port shows stored value until the edge
    pc_le = 1'b1; pc_in = 32'd4; rb = 4'd15; #1;
    check("t4_pb_pre0", pb, 32'h0);
    tick();
    check("t4_pc_4", pc_out, 32'd4);
    pc_in = 32'd8; #1;
    check("t4_pb_pre4", pb, 32'd4);
    tick();
    check("t4_pc_8", pc_out, 32'd8);
    pc_in = 32'd12; #1;
    check("t4_pb_pre8", pb, 32'd8);
    tick();
    check("t4_pc_12", pc_out, 32'd12);
    pc_le = 1'b0;

    // T5 PC conflict: WB write to R15 wins; bypass applies to R15 reads but not pc_out
    le = 1'b1; rw = 4'd15; pw = 32'h100; pc_le = 1'b1; pc_in = 32'h20; rb = 4'd15; #1;
    check("t5_pb_bypass", pb, 32'h100);
    check("t5_pc_out_pre", pc_out, 32'd12);
    tick();
    le = 1'b0; pc_le = 1'b0; #1;
    check("t5_pc_out", pc_out, 32'h100);

    // PC load alongside a WB write to another register
    le = 1'b1; rw = 4'd3; pw = 32'h33; pc_le = 1'b1; pc_in = 32'h200;
    tick();
    le = 1'b0; pc_le = 1'b0; ra = 4'd3; #1;
    check("dual_r3", pa, 32'h33);
    check("dual_pc", pc_out, 32'h200);

    // T6 reset mid-stream
    le = 1'b1; rw = 4'd2; pw = 32'd9;
    tick();
    le = 1'b0; ra = 4'd2; #1;
    check("t6_r2_pre", pa, 32'd9);
    rst_n = 1'b0; le = 1'b1; rw = 4'd2; pw = 32'd5; pc_le = 1'b1; pc_in = 32'h44;
    tick();
    rst_n = 1'b1; le = 1'b0; pc_le = 1'b0; ra = 4'd2; rb = 4'd5; rd = 4'd7; #1;
    check("t6_r2", pa, 32'h0);
    check("t6_r5", pb, 32'h0);
    check("t6_r7", pd, 32'h0);
    check("t6_pc_out", pc_out, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish required finish");
    $fatal(1, "timeout");
  end
endmodule
